qsn_rotator_pipe: RTL
=====================

// Module: qsn_rotator_pipe
// PURPOSE
// - Parametrised successor to the fixed-size 85-lane, 4-bit QSN permutation top.
// - Cyclically rotates Z lanes of Q-bit messages by a runtime shift amount, in either direction.
// - Split into left/right/merge networks with internal select generation and PIPE_STAGES register stages.
// - Valid/ready handshake on both sides. Sits between the layered-decoder memories and the VNU/CNU arrays.
// PARAMETERS
// - Z           85  lanes (circulant size), Z >= 2
// - Q           4   bits per lane message
// - PIPE_STAGES 2   register stages, legal 1..3 (1: output reg only; 2: +after left/right; 3: +input reg)
// - SW          $clog2(Z)  shift-amount width (derived localparam, not overridable)
// PORTS
// - sys_clk    in   1    clock, all state on rising edge
// - rst        in   1    asynchronous reset, active-high
// - in_valid   in   1    input beat valid
// - in_ready   out  1    block can accept a beat this cycle
// - in_data    in   Z*Q  lane k = in_data[k*Q +: Q]
// - shift_amt  in   SW   rotation amount, legal 0..Z-1
// - dir        in   1    0: out[k]=in[(k+s)%Z] (up-rotate); 1: out[k]=in[(k-s+Z)%Z]
// - out_valid  out  1    output beat valid
// - out_ready  in   1    downstream accepts the beat
// - out_data   out  Z*Q  rotated lanes, same packing as in_data
// - err_shift  out  1    sticky: an illegal shift_amt (>= Z) was accepted
// BEHAVIOUR
// - Reset (async assert, sync deassert by the clock): all stage valids 0, out_valid=0, out_data=0, err_shift=0. in_ready=1 from the first cycle after reset.
// - Transfer occurs when valid && ready on that side.
// - Global stall: en = !(out_valid && !out_ready). in_ready = en. When en=0, every stage holds data and valid.
// - Latency: a beat accepted in cycle t appears on out_valid in cycle t+PIPE_STAGES when there is no stall.
//   Throughput is 1 beat/cycle. Beat order is always preserved; bubbles are not collapsed.
// - Internal shift normalisation:
//   - s_eff = (dir==0) ? s : (s==0 ? 0 : Z-s).
//   - Selects: left_sel = s_eff; right_sel = Z-s_eff.
//   - merge_sel[k] = 1 picks the left path for lanes k < Z-s_eff, else the right path.
// - Illegal shift (shift_amt >= Z, possible when Z is not a power of 2):
//   - the beat is still accepted, with s forced to 0 (pass-through);
//   - err_shift is set in the cycle after acceptance and is held until rst.
// - s=0 with either dir: out_data == in_data exactly.
// - Simultaneous accept and drain while full: both occur and the pipeline advances.
// - Reset mid-operation: in-flight beats are discarded and out_valid drops immediately (async).
// - out_data is stable while out_valid && !out_ready (AXI-style hold). Beats are never dropped or duplicated.
// - Selects and shift travel with the data through each stage; no cross-beat dependence.
// STRUCTURE
// - Shared package qsn_pkg: QSN_Z_DEF, QSN_Q_DEF, the SW width function, and the dir encodings
//   (QSN_DIR_UP=0, QSN_DIR_DN=1).
// - Sub-module qsn_sel_gen: combinational decode of {shift_amt, dir} to left_sel, right_sel,
//   merge_sel[Z-2:0] and the illegal flag. Instantiated once per beat, not per bit-plane.
// - Top: generate loop over Q bit-planes, each with parametrised left/right/merge logic,
//   plus the stage registers and the stall logic.
// TESTING (Z=85, Q=4, PIPE_STAGES=2 unless noted)
// 1. Reset: hold rst for 3 cycles -> out_valid=0, out_data=0, err_shift=0; in_ready=1 after release.
// 2. Lane 0 = 4'hA, others 0, s=1, dir=0 -> 2 cycles later out lane 84 = 4'hA, all others 0.
// 3. Same input, s=84, dir=1 -> out lane 84 = 4'hA. Also s=0 with either dir -> out_data == in_data.
// 4. Backpressure: stream 5 beats with s = 0..4 and hold out_ready=0 for 6 cycles ->
//    in_ready=0 once full, no beat lost, outputs emerge in order, each matching the model.
// 5. shift_amt=90 with random data -> out_data == in_data, err_shift=1 and stays 1 after later legal beats.
// 6. Assert rst while 2 beats are in flight -> out_valid=0 at once; after release, the next beat has latency 2.
// - Random regression, PIPE_STAGES in {1,2,3} and Z in {85,64,7}: 10k beats with a random out_ready pattern,
//   compared against the reference rotation model.

Source files
------------

// File: rtl/qsn_pkg.sv
// Shared constants, direction encodings and width helper for the QSN rotator.
package qsn_pkg;

  localparam int QSN_Z_DEF = 85;
  localparam int QSN_Q_DEF = 4;

  typedef enum logic {
    QSN_DIR_UP = 1'b0,
    QSN_DIR_DN = 1'b1
  } qsn_dir_e;

  function automatic int qsn_sw(input int z);
    return $clog2(z);
  endfunction

endpackage

// File: rtl/qsn_rotator_pipe_if.sv
// Beat interface for the QSN rotator: input side, output side and sticky error flag.
interface qsn_rotator_pipe_if
  import qsn_pkg::*;
#(
  parameter int Z = QSN_Z_DEF,
  parameter int Q = QSN_Q_DEF
);
  localparam int SW = qsn_sw(Z);

  // A beat moves on a side in the cycle where valid && ready; a producer holds
  // valid and its payload steady until that cycle, and ready never waits on valid.
  logic           in_valid;
  logic           in_ready;
  logic [Z*Q-1:0] in_data;
  logic [SW-1:0]  shift_amt;
  logic           dir;
  logic           out_valid;
  logic           out_ready;
  logic [Z*Q-1:0] out_data;
  logic           err_shift;

  modport master (
    output in_valid, in_data, shift_amt, dir, out_ready,
    input  in_ready, out_valid, out_data, err_shift
  );

  modport slave (
    input  in_valid, in_data, shift_amt, dir, out_ready,
    output in_ready, out_valid, out_data, err_shift
  );

endinterface

// File: rtl/qsn_sel_gen.sv
// Decodes {shift_amt, dir} into left/right shift selects, per-lane merge selects
// and an illegal-shift flag; an illegal shift collapses to pass-through.
module qsn_sel_gen
  import qsn_pkg::*;
#(
  parameter  int Z  = QSN_Z_DEF,
  localparam int SW = qsn_sw(Z)
) (
  input  logic [SW-1:0] shift_amt,
  input  logic          dir,
  output logic [SW-1:0] left_sel,
  output logic [SW:0]   right_sel,
  output logic [Z-2:0]  merge_sel,
  output logic          illegal
);
  localparam logic [SW:0] Z_W = (SW+1)'(Z);

  logic [SW-1:0] s;
  logic [SW-1:0] s_eff;

  // merge_sel[j] steers lane j+1; lane 0 always takes the left path.
  always_comb begin
    illegal = ({1'b0, shift_amt} >= Z_W);
    s       = illegal ? '0 : shift_amt;
    if (qsn_dir_e'(dir) == QSN_DIR_UP || s == '0) s_eff = s;
    else                                           s_eff = SW'(Z_W - {1'b0, s});
    left_sel  = s_eff;
    right_sel = Z_W - {1'b0, s_eff};
    for (int j = 0; j < Z-1; j++) begin
      merge_sel[j] = (({1'b0, s_eff} + (SW+1)'(j + 1)) < Z_W);
    end
  end

endmodule

// File: rtl/qsn_rotator_pipe.sv
// Pipelined cyclic lane rotator: bit-plane left/right shifters plus merge, with
// optional input and mid registers and a global stall driven by the output side.
module qsn_rotator_pipe
  import qsn_pkg::*;
#(
  parameter int Z           = QSN_Z_DEF,
  parameter int Q           = QSN_Q_DEF,
  parameter int PIPE_STAGES = 2
) (
  input logic               sys_clk,
  input logic               rst,
  qsn_rotator_pipe_if.slave bus
);
  localparam int SW = qsn_sw(Z);
  localparam int W  = Z * Q;

  logic         en;
  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic         err_q;

  assign en            = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err_shift = err_q;

  logic [SW-1:0] lsel0;
  logic [SW:0]   rsel0;
  logic [Z-2:0]  msel0;
  logic          illegal0;

  qsn_sel_gen #(.Z(Z)) u_sel_gen (
    .shift_amt (bus.shift_amt),
    .dir       (bus.dir),
    .left_sel  (lsel0),
    .right_sel (rsel0),
    .merge_sel (msel0),
    .illegal   (illegal0)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                               err_q <= 1'b0;
    else if (bus.in_valid && en && illegal0) err_q <= 1'b1;
  end

  logic          v1;
  logic [W-1:0]  d1;
  logic [SW-1:0] lsel1;
  logic [SW:0]   rsel1;
  logic [Z-2:0]  msel1;

  if (PIPE_STAGES >= 3) begin : g_in_reg
    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        v1    <= 1'b0;
        d1    <= '0;
        lsel1 <= '0;
        rsel1 <= '0;
        msel1 <= '0;
      end else if (en) begin
        v1    <= bus.in_valid;
        d1    <= bus.in_data;
        lsel1 <= lsel0;
        rsel1 <= rsel0;
        msel1 <= msel0;
      end
    end
  end else begin : g_in_wire
    assign v1    = bus.in_valid;
    assign d1    = bus.in_data;
    assign lsel1 = lsel0;
    assign rsel1 = rsel0;
    assign msel1 = msel0;
  end

  // Left path: lane k <- lane k+s_eff. Right path: lane k <- lane k-(Z-s_eff).
  logic [W-1:0] l1;
  logic [W-1:0] r1;

  for (genvar b = 0; b < Q; b++) begin : g_plane_lr
    logic [Z-1:0] plane;
    logic [Z-1:0] lp;
    logic [Z-1:0] rp;
    for (genvar k = 0; k < Z; k++) begin : g_lane
      assign plane[k]   = d1[k*Q+b];
      assign l1[k*Q+b]  = lp[k];
      assign r1[k*Q+b]  = rp[k];
    end
    assign lp = plane >> lsel1;
    assign rp = plane << rsel1;
  end

  logic         v2;
  logic [W-1:0] l2;
  logic [W-1:0] r2;
  logic [Z-2:0] msel2;

  if (PIPE_STAGES >= 2) begin : g_mid_reg
    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        v2    <= 1'b0;
        l2    <= '0;
        r2    <= '0;
        msel2 <= '0;
      end else if (en) begin
        v2    <= v1;
        l2    <= l1;
        r2    <= r1;
        msel2 <= msel1;
      end
    end
  end else begin : g_mid_wire
    assign v2    = v1;
    assign l2    = l1;
    assign r2    = r1;
    assign msel2 = msel1;
  end

  logic [W-1:0] m2;

  for (genvar b = 0; b < Q; b++) begin : g_plane_m
    for (genvar k = 0; k < Z; k++) begin : g_lane
      if (k == 0) begin : g_first
        assign m2[b] = l2[b];
      end else begin : g_rest
        assign m2[k*Q+b] = msel2[k-1] ? l2[k*Q+b] : r2[k*Q+b];
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      out_valid_q <= v2;
      out_data_q  <= m2;
    end
  end

endmodule
